// File: rtl/hit_judge.sv
// hit_judge: per-frame player/boss hit arbitration; HIT_BOSS_PHASE_EN adds the boss phase output
module hit_judge #(
  parameter int BOSS_HP  = 100,
  parameter int HP_W     = 8,
  parameter int BOMB_DMG = 4
) (
  input  logic            clk,
  input  logic            hard_reset,
  input  logic            game_en_i,
  input  logic            game_reset_i,
  input  logic [4:0]      game_state_i,
  input  logic            pixel_valid_i,
  input  logic            player_px_i,
  input  logic            ebullet_px_i,
  input  logic            boss_px_i,
  input  logic            pbullet_px_i,
  input  logic            frame_end_i,
  output logic            collision_o,
  output logic            die_o,
  output logic [HP_W-1:0] boss_hp_o,
  output logic [1:0]      boss_phase_o
);
  localparam logic [4:0] ST_PLAY = 5'b00010;
  localparam logic [4:0] ST_BOMB = 5'b00110;
  typedef enum logic [1:0] {IDLE, SCAN, JUDGE, DEAD} state_t;
  state_t state_q, state_d;
  logic p_hit_q, p_hit_d, b_hit_q, b_hit_d;
  logic coll_q, coll_d, die_q, die_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [HP_W:0] dmg;
  logic p_px, b_px;
  assign p_px = pixel_valid_i & player_px_i & ebullet_px_i;
  assign b_px = pixel_valid_i & boss_px_i & pbullet_px_i;
  assign dmg = (HP_W+1)'(b_hit_q) + ((game_state_i == ST_BOMB) ? (HP_W+1)'(BOMB_DMG) : '0);
  always_comb begin
    state_d = state_q;
    p_hit_d = p_hit_q;
    b_hit_d = b_hit_q;
    coll_d  = 1'b0;
    die_d   = die_q;
    hp_d    = hp_q;
    if (game_reset_i) begin
      state_d = IDLE;
      p_hit_d = 1'b0;
      b_hit_d = 1'b0;
      die_d   = 1'b0;
      hp_d    = HP_W'(BOSS_HP);
    end else begin
      case (state_q)
        IDLE: begin
          p_hit_d = 1'b0;
          b_hit_d = 1'b0;
          state_d = game_en_i ? SCAN : IDLE;
        end
        SCAN: begin
          p_hit_d = game_en_i & (p_hit_q | p_px);
          b_hit_d = game_en_i & (b_hit_q | b_px);
          state_d = !game_en_i ? IDLE : frame_end_i ? JUDGE : SCAN;
        end
        JUDGE: begin
          hp_d    = ({1'b0, hp_q} > dmg) ? hp_q - dmg[HP_W-1:0] : '0;
          die_d   = (hp_d == '0);
          coll_d  = !die_d & p_hit_q & (game_state_i == ST_PLAY);
          // pixels seen while judging open the next frame
          p_hit_d = !die_d & p_px;
          b_hit_d = !die_d & b_px;
          state_d = die_d ? DEAD : game_en_i ? SCAN : IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      state_q <= IDLE;
      p_hit_q <= 1'b0;
      b_hit_q <= 1'b0;
      coll_q  <= 1'b0;
      die_q   <= 1'b0;
      hp_q    <= HP_W'(BOSS_HP);
    end else begin
      state_q <= state_d;
      p_hit_q <= p_hit_d;
      b_hit_q <= b_hit_d;
      coll_q  <= coll_d;
      die_q   <= die_d;
      hp_q    <= hp_d;
    end
  end
  assign collision_o = coll_q;
  assign die_o       = die_q;
  assign boss_hp_o   = hp_q;
`ifdef HIT_BOSS_PHASE_EN
  localparam logic [HP_W-1:0] T_HI = HP_W'((2 * BOSS_HP) / 3);
  localparam logic [HP_W-1:0] T_LO = HP_W'(BOSS_HP / 3);
  logic [1:0] phase_q, phase_d;
  assign phase_d = (hp_d > T_HI) ? 2'd0 : (hp_d > T_LO) ? 2'd1 : (hp_d != '0) ? 2'd2 : 2'd3;
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) phase_q <= 2'd0;
    else phase_q <= phase_d;
  end
  assign boss_phase_o = phase_q;
`else
  assign boss_phase_o = 2'b00;
`endif
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed self-checking bench for hit_judge
module tb_hit_judge;
  localparam logic [4:0] PLAY = 5'b00010;
  localparam logic [4:0] COLL = 5'b01010;
  localparam logic [4:0] BOMB = 5'b00110;
  logic clk = 1'b0;
  logic hard_reset = 1'b1;
  logic game_en = 1'b0;
  logic game_reset = 1'b0;
  logic [4:0] game_state = PLAY;
  logic pixel_valid = 1'b0;
  logic player_px = 1'b0;
  logic ebullet_px = 1'b0;
  logic boss_px = 1'b0;
  logic pbullet_px = 1'b0;
  logic frame_end = 1'b0;
  logic collision, die;
  logic [7:0] boss_hp;
  logic [1:0] boss_phase;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  hit_judge dut (
    .clk(clk), .hard_reset(hard_reset), .game_en_i(game_en), .game_reset_i(game_reset),
    .game_state_i(game_state), .pixel_valid_i(pixel_valid), .player_px_i(player_px),
    .ebullet_px_i(ebullet_px), .boss_px_i(boss_px), .pbullet_px_i(pbullet_px),
    .frame_end_i(frame_end), .collision_o(collision), .die_o(die),
    .boss_hp_o(boss_hp), .boss_phase_o(boss_phase)
  );
  function automatic logic [1:0] ph(input int h);
`ifdef HIT_BOSS_PHASE_EN
    return (h > 66) ? 2'd0 : (h > 33) ? 2'd1 : (h > 0) ? 2'd2 : 2'd3;
`else
    return 2'd0;
`endif
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic pix(input logic pp, input logic bb);
    pixel_valid = pp | bb;
    player_px = pp;
    ebullet_px = pp;
    boss_px = bb;
    pbullet_px = bb;
  endtask
  task automatic chk_coll(input logic e, input string tag);
    n_chk++;
    assert (collision === e) else begin
      n_fail++;
      $error("FAIL %s: collision=%b expected %b", tag, collision, e);
    end
  endtask
  task automatic chk(input logic ec, input logic ed, input int eh, input string tag);
    chk_coll(ec, tag);
    n_chk++;
    assert (die === ed) else begin
      n_fail++;
      $error("FAIL %s: die=%b expected %b", tag, die, ed);
    end
    n_chk++;
    assert (boss_hp === 8'(eh)) else begin
      n_fail++;
      $error("FAIL %s: boss_hp=%0d expected %0d", tag, boss_hp, eh);
    end
    n_chk++;
    assert (boss_phase === ph(eh)) else begin
      n_fail++;
      $error("FAIL %s: boss_phase=%0d expected %0d", tag, boss_phase, ph(eh));
    end
  endtask
  // one overlap pixel, then frame_end; outputs checked in the judge cycle, N+2 and N+3
  task automatic frame(input logic pp, input logic bb, input logic [4:0] st,
                       input logic ec, input logic ed, input int eh, input string tag);
    game_state = st;
    pix(pp, bb);
    step;
    pix(1'b0, 1'b0);
    frame_end = 1'b1;
    step;
    frame_end = 1'b0;
    chk_coll(1'b0, {tag, " judge"});
    step;
    chk(ec, ed, eh, tag);
    step;
    chk_coll(1'b0, {tag, " after"});
  endtask
  task automatic greset(input string tag);
    game_reset = 1'b1;
    step;
    game_reset = 1'b0;
    chk(1'b0, 1'b0, 100, tag);
    step;
  endtask
  initial begin
    step;
    step;
    chk(1'b0, 1'b0, 100, "hard_reset");
    hard_reset = 1'b0;
    step;
    frame(1'b1, 1'b1, PLAY, 1'b0, 1'b0, 100, "disabled");
    game_en = 1'b1;
    step;
    frame(1'b1, 1'b0, PLAY, 1'b1, 1'b0, 100, "play_hit");
    frame(1'b1, 1'b0, COLL, 1'b0, 1'b0, 100, "invuln");
    game_state = PLAY;
    pix(1'b0, 1'b1);
    frame_end = 1'b1;
    step;
    pix(1'b0, 1'b0);
    frame_end = 1'b0;
    step;
    chk(1'b0, 1'b0, 99, "fe_pixel");
    frame_end = 1'b1;
    step;
    frame_end = 1'b0;
    pix(1'b0, 1'b1);
    step;
    pix(1'b0, 1'b0);
    chk(1'b0, 1'b0, 99, "judge_px_now");
    frame(1'b0, 1'b0, PLAY, 1'b0, 1'b0, 98, "judge_px_next");
    pix(1'b1, 1'b1);
    step;
    pix(1'b0, 1'b0);
    game_en = 1'b0;
    step;
    game_en = 1'b1;
    step;
    frame(1'b0, 1'b0, PLAY, 1'b0, 1'b0, 98, "drop");
    frame(1'b1, 1'b1, PLAY, 1'b1, 1'b0, 97, "both");
    for (int k = 1; k <= 3; k++) frame(1'b0, 1'b1, PLAY, 1'b0, 1'b0, 97 - k, "boss");
    for (int k = 1; k <= 23; k++) frame(1'b1, 1'b0, BOMB, 1'b0, 1'b0, 94 - 4 * k, "bomb");
    frame(1'b0, 1'b0, BOMB, 1'b0, 1'b1, 0, "saturate");
    frame(1'b1, 1'b1, PLAY, 1'b0, 1'b1, 0, "dead_play");
    game_en = 1'b0;
    greset("reset1");
    frame(1'b1, 1'b1, PLAY, 1'b0, 1'b0, 100, "off_play");
    frame(1'b1, 1'b1, BOMB, 1'b0, 1'b0, 100, "off_bomb");
    game_en = 1'b1;
    step;
    for (int k = 1; k <= 19; k++) frame(1'b1, 1'b1, BOMB, 1'b0, 1'b0, 100 - 5 * k, "bomb_boss");
    frame(1'b1, 1'b1, BOMB, 1'b0, 1'b1, 0, "exact_zero");
    greset("reset2");
    for (int k = 1; k <= 67; k++) frame(1'b0, 1'b1, PLAY, 1'b0, 1'b0, 100 - k, "phase");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
